// File: rtl/traceback_3d.sv
// Traceback engine for a three-sequence alignment. It follows predecessor pointers from an
// end cell back to the origin and emits one alignment column per step under ready/valid.
module traceback_3d #(
    parameter int LEN_W = 6,
    parameter int CNT_W = LEN_W + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     end_i,
    input  logic [LEN_W-1:0]     end_j,
    input  logic [LEN_W-1:0]     end_k,
    input  logic [2:0]           start_state,
    output logic                 rd_en,
    output logic [3*LEN_W+2:0]   rd_addr,
    input  logic [2:0]           rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_col,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     step_cnt
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, FIN} fsm_t;

    localparam logic [2:0] CODE_BAD = 3'd7;

    fsm_t             state, state_nxt;
    logic [LEN_W-1:0] idx_i, idx_j, idx_k;
    logic [LEN_W-1:0] nxt_i, nxt_j, nxt_k;
    logic [2:0]       cur, pred;
    logic             dec_i, dec_j, dec_k;
    logic             bad_read, start_zero, origin_next;

    // Which indices the current matrix code consumes.
    always_comb begin
        {dec_i, dec_j, dec_k} = 3'b000;
        case (cur)
            3'd0:    {dec_i, dec_j, dec_k} = 3'b111;
            3'd1:    {dec_i, dec_j, dec_k} = 3'b110;
            3'd2:    {dec_i, dec_j, dec_k} = 3'b011;
            3'd3:    {dec_i, dec_j, dec_k} = 3'b101;
            3'd4:    {dec_i, dec_j, dec_k} = 3'b100;
            3'd5:    {dec_i, dec_j, dec_k} = 3'b010;
            3'd6:    {dec_i, dec_j, dec_k} = 3'b001;
            default: {dec_i, dec_j, dec_k} = 3'b000;
        endcase
    end

    assign bad_read    = (cur == CODE_BAD) || (dec_i && idx_i == '0)
                      || (dec_j && idx_j == '0) || (dec_k && idx_k == '0);
    assign nxt_i       = idx_i - LEN_W'(dec_i);
    assign nxt_j       = idx_j - LEN_W'(dec_j);
    assign nxt_k       = idx_k - LEN_W'(dec_k);
    assign origin_next = (nxt_i == '0) && (nxt_j == '0) && (nxt_k == '0);
    assign start_zero  = (end_i == '0) && (end_j == '0) && (end_k == '0);

    // NOTE: rst_n is sampled on the clock edge only, so it is absent from the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_nxt = state;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = start_zero ? FIN : READ;
            end
            READ: begin
                if (bad_read) begin
                    state_nxt = FIN;
                end else begin
                    rd_en     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: state_nxt = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = (pred == CODE_BAD || origin_next) ? FIN : READ;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_addr = rd_en     ? {idx_i, idx_j, idx_k, cur} : '0;
    assign out_col = out_valid ? cur : 3'd0;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_i    <= '0;
            idx_j    <= '0;
            idx_k    <= '0;
            cur      <= '0;
            pred     <= '0;
            err      <= 1'b0;
            step_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx_i    <= end_i;
                    idx_j    <= end_j;
                    idx_k    <= end_k;
                    cur      <= start_state;
                    err      <= 1'b0;
                    step_cnt <= '0;
                end
                READ: if (bad_read) err <= 1'b1;
                WAIT: pred <= rd_data;
                EMIT: if (out_ready) begin
                    idx_i <= nxt_i;
                    idx_j <= nxt_j;
                    idx_k <= nxt_k;
                    cur   <= pred;
                    if (step_cnt != '1) step_cnt <= step_cnt + CNT_W'(1);
                    if (pred == CODE_BAD) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
